// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: hex glyph table, all-off pattern and decode helper.
// Patterns are active-high with bit 0 = segment a through bit 6 = segment g.
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered hex digits, leading-zero
// blanking, per-slot dead time and configurable anode/segment polarity.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD_CYCLES    = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_IDLE = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  slot_end;
  logic                  boundary;

  logic [VW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;
  logic [VW-1:0]         act_val;
  logic [NUM_DIGITS-1:0] act_dp;

  logic [3:0]            nib_p0;
  logic [6:0]            hex_p0;
  logic                  blank_p0;
  logic                  vld_p0;
  logic [6:0]            pat_p0;
  logic [NUM_DIGITS-1:0] onehot_p0;

  assign slot_end = (cnt == CW'(CLK_DIV - 1));
  assign boundary = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // A load landing on the boundary cycle lands in pending after the transfer,
  // so it is shown one frame later and pend_valid stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
    end else begin
      if (boundary && pend_valid) begin
        act_val    <= pend_val;
        act_dp     <= pend_dp;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp;
        pend_valid <= 1'b1;
      end
    end
  end

  // Stage p0: select the current digit, decode it and decide blanking
  assign nib_p0 = act_val[{idx, 2'b00} +: 4];

  sevenseg_hex_decode u_hex_decode (
    .nibble (nib_p0),
    .seg    (hex_p0)
  );

  assign blank_p0  = BLANK_LEADING && (idx != '0) && ((act_val >> {idx, 2'b00}) == '0);
  assign vld_p0    = enable && (cnt >= CW'(DEAD_CYCLES));
  assign pat_p0    = blank_p0 ? SEG_OFF : hex_p0;
  assign onehot_p0 = NUM_DIGITS'(1) << idx;

  // Stage p1: registered pin drive with polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      an     <= AN_IDLE;
      seg    <= SEG_IDLE;
      dp_out <= SEG_ACTIVE_LOW;
    end else if (vld_p0) begin
      an     <= onehot_p0 ^ AN_IDLE;
      seg    <= pat_p0 ^ {7{SEG_ACTIVE_LOW}};
      dp_out <= act_dp[idx] ^ SEG_ACTIVE_LOW;
    end else begin
      an     <= AN_IDLE;
      seg    <= SEG_IDLE;
      dp_out <= SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: three polarity/blanking variants share one stimulus
// stream and are checked every cycle against a frame-position reference model.
module tb_sevenseg_scan_driver;

  localparam int N    = 4;
  localparam int CD   = 4;
  localparam int DEAD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;

  logic [3:0]  o_an  [3];
  logic [6:0]  o_seg [3];
  logic        o_dp  [3];
  logic        o_fd  [3];

  int ncmp = 0;
  int nbad = 0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          mcyc = 0;
  logic [15:0] m_val = '0, m_pval = '0;
  logic [3:0]  m_dp = '0, m_pdp = '0;
  bit          m_pv = 1'b0;

  always #5 clk = ~clk;

  // a: default style, b: no leading-zero blanking, c: active-low segments
  sevenseg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DEAD),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_a (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(o_seg[0]), .dp_out(o_dp[0]), .an(o_an[0]), .frame_done(o_fd[0]));

  sevenseg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DEAD),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u_b (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(o_seg[1]), .dp_out(o_dp[1]), .an(o_an[1]), .frame_done(o_fd[1]));

  sevenseg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .DEAD_CYCLES(DEAD),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_c (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(o_seg[2]), .dp_out(o_dp[2]), .an(o_an[2]), .frame_done(o_fd[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the pins after the next edge from the frame position, then clock and compare.
  task automatic step();
    logic [3:0] e_an  [3];
    logic [6:0] e_seg [3];
    logic       e_dp  [3];
    logic       e_fd;
    int pos, slot, dig;
    bit lit, bl, sal, blank;
    logic [6:0] pat;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        sal = (c == 2);
        e_an[c]  = 4'hF;
        e_seg[c] = sal ? 7'h7F : 7'h00;
        e_dp[c]  = sal;
      end
      e_fd = 1'b0;
      mcyc = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pv = 1'b0;
    end else begin
      pos  = mcyc % (N * CD);
      slot = pos % CD;
      dig  = pos / CD;
      lit  = (slot >= DEAD) && enable;
      e_fd = (pos == N * CD - 1);
      for (int c = 0; c < 3; c++) begin
        bl  = (c != 1);
        sal = (c == 2);
        if (!lit) begin
          e_an[c]  = 4'hF;
          e_seg[c] = sal ? 7'h7F : 7'h00;
          e_dp[c]  = sal;
        end else begin
          blank    = bl && (dig != 0) && ((m_val >> (4 * dig)) == 16'h0);
          pat      = blank ? 7'h00 : glyph[m_val[4*dig +: 4]];
          e_an[c]  = ~(4'b0001 << dig);
          e_seg[c] = sal ? ~pat : pat;
          e_dp[c]  = m_dp[dig] ^ sal;
        end
      end
      if (e_fd && m_pv) begin
        m_val = m_pval; m_dp = m_pdp; m_pv = 1'b0;
      end
      if (load) begin
        m_pval = value; m_pdp = dp; m_pv = 1'b1;
      end
      mcyc++;
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("an%0d", c),  o_an[c],  e_an[c]);
      chk($sformatf("seg%0d", c), o_seg[c], e_seg[c]);
      chk($sformatf("dp%0d", c),  o_dp[c],  e_dp[c]);
      chk($sformatf("fd%0d", c),  o_fd[c],  e_fd);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!o_fd[0] && n < 64);
    chk(tag, o_fd[0], 1'b1);
  endtask

  task automatic load_one(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] mask;

    steps(3);
    chk("rst_an", o_an[0], 4'hF);
    chk("rst_seg", o_seg[0], 7'h00);
    chk("rst_fd", o_fd[0], 1'b0);
    chk("rst_seg_al", o_seg[2], 7'h7F);
    rst = 1'b0;

    load_one(16'h12AF, 4'b0100);
    wait_fd("fd_first");
    steps(2);
    chk("d0_an", o_an[0], 4'b1110);  chk("d0_seg", o_seg[0], 7'h71);
    steps(4);
    chk("d1_an", o_an[0], 4'b1101);  chk("d1_seg", o_seg[0], 7'h77);
    steps(4);
    chk("d2_an", o_an[0], 4'b1011);  chk("d2_seg", o_seg[0], 7'h5B);
    chk("d2_dp", o_dp[0], 1'b1);
    steps(4);
    chk("d3_an", o_an[0], 4'b0111);  chk("d3_seg", o_seg[0], 7'h06);
    wait_fd("fd_align");
    n = 0;
    do begin
      step();
      n++;
    end while (!o_fd[0] && n < 64);
    chk("fd_period", n, 16);

    steps(3);
    load_one(16'h1111, 4'b0000);
    steps(7);
    chk("dbuf_hold", o_seg[0], 7'h5B);
    steps(4);
    load_one(16'h2222, 4'b0000);
    chk("dbuf_fd", o_fd[0], 1'b1);
    steps(2);
    chk("dbuf_1111", o_seg[0], 7'h06);
    wait_fd("fd_2222");
    steps(2);
    chk("dbuf_2222", o_seg[0], 7'h5B);

    load_one(16'h0030, 4'b0000);
    wait_fd("fd_0030");
    steps(2);
    chk("lz_d0", o_seg[0], 7'h3F);
    steps(4);
    chk("lz_d1", o_seg[0], 7'h4F);
    steps(4);
    chk("lz_d2", o_seg[0], 7'h00);   chk("lz_d2_an", o_an[0], 4'b1011);
    chk("lz_d2_nobl", o_seg[1], 7'h3F);
    chk("lz_d2_al", o_seg[2], 7'h7F);
    steps(4);
    chk("lz_d3", o_seg[0], 7'h00);   chk("lz_d3_nobl", o_seg[1], 7'h3F);
    load_one(16'h0000, 4'b0000);
    wait_fd("fd_0000");
    steps(2);
    chk("zero_d0", o_seg[0], 7'h3F);
    steps(4);
    chk("zero_d1", o_seg[0], 7'h00); chk("zero_d1_nobl", o_seg[1], 7'h3F);

    wait_fd("fd_en");
    steps(5);
    enable = 1'b0;
    step();
    chk("en_off", o_an[0], 4'hF);
    steps(4);
    enable = 1'b1;
    step();
    chk("en_resume", o_an[0], 4'b1011);

    load_one(16'h0008, 4'b0000);
    wait_fd("fd_8");
    steps(2);
    chk("al_8", o_seg[2], 7'h00);
    chk("ah_8", o_seg[0], 7'h7F);

    load_one(16'h4321, 4'b0000);
    wait_fd("fd_4321");
    load_one(16'h9999, 4'b1111);
    steps(8);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(2);
    chk("mrst_an", o_an[0], 4'b1110);
    chk("mrst_d0", o_seg[0], 7'h3F);
    steps(4);
    chk("mrst_d1", o_seg[0], 7'h00);
    steps(40);

    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 4))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        3:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      value  = 16'($urandom) & mask;
      dp     = 4'($urandom);
      load   = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 19) != 0);
      rst    = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0; enable = 1'b1;
    steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode/cathode seven-segment digits sharing one segment bus.
- Takes a packed 4-bit-per-digit value plus per-digit decimal points, decodes hex 0-F, and scans the digits at a programmable rate.
- Adds tear-free double buffering, leading-zero blanking, inter-digit dead time and configurable output polarity.
- Sits between counter/datapath logic and the board pins; successor to the single-digit combinational BCD decoder.

Parameters:
- NUM_DIGITS, 4: digits driven, 2..8.
- CLK_DIV, 50000: clock cycles per digit slot, >= 2.
- DEAD_CYCLES, 8: cycles at the start of each slot with all anodes inactive, < CLK_DIV.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp_out.
- AN_ACTIVE_LOW, 1: 1 means anode asserted = 0.
- BLANK_LEADING, 1: 1 enables leading-zero blanking.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- value, in, 4*NUM_DIGITS: nibble k drives digit k; digit 0 is least significant/rightmost.
- dp, in, NUM_DIGITS: decimal point per digit, 1 = lit.
- load, in, 1: capture value/dp into the pending buffer.
- enable, in, 1: 0 forces all anodes inactive; scanning counters keep running.
- seg, out, 7: segments, seg[0]=a .. seg[6]=g.
- dp_out, out, 1: decimal point segment.
- an, out, NUM_DIGITS: digit enables, one-hot when active.
- frame_done, out, 1: one-cycle pulse at the end of the last slot.

Behaviour:
- Reset: cnt=0, idx=0, pending=0, active=0, pend_valid=0. an = all inactive level, seg = all-off level, dp_out = off level, frame_done=0.
- Slot counter:
  - cnt counts 0..CLK_DIV-1.
  - On cnt==CLK_DIV-1: cnt <= 0 and idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
  - A frame is NUM_DIGITS*CLK_DIV cycles.
- frame_done is asserted (registered) the cycle after cnt==CLK_DIV-1 && idx==NUM_DIGITS-1, i.e. coincident with idx returning to 0.
- Load: when load=1, pending <= {value, dp} and pend_valid <= 1. Back-to-back loads are allowed; the last one wins.
- Buffer transfer: at the frame boundary (the same condition as frame_done), if pend_valid, then active <= pending and pend_valid <= 0.
  - If load and the boundary coincide, the new load goes to pending and pend_valid stays 1.
  - The previous pending value is transferred to active, so it becomes visible one frame later.
- Decode, active-high before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
- Leading-zero blanking:
  - Digit k is blank when BLANK_LEADING=1, k != 0, and nibbles k..NUM_DIGITS-1 of active are all zero.
  - A blank digit drives seg = all off but still shows its dp.
  - Digit 0 is never blanked.
- Outputs are registered, with one-cycle latency from (cnt, idx, active):
  - During cnt < DEAD_CYCLES, or when enable=0: an = inactive, seg = off, dp_out = off.
  - Otherwise: an = one-hot idx, seg = decode(active nibble idx) or blank, dp_out = active dp[idx].
  - Polarity parameters are applied at the output register.
- Reset mid-frame: everything returns to reset values next edge, and pending data is discarded.
- enable deasserting mid-slot blanks from the next cycle. Scan position is unaffected, so re-enabling resumes in phase.

Decomposition:
- Shared package sevenseg_pkg holds:
  - the 16-entry SEG_HEX constant table;
  - SEG_OFF;
  - a function hex_to_seg(nibble).
- One sub-module, sevenseg_hex_decode: combinational nibble -> 7-bit active-high pattern, reusable by other display blocks.
- Scan counter, buffers, blanking and output registers stay in the top module.

Test Plan:
- Reset: hold rst 3 cycles with NUM_DIGITS=4, CLK_DIV=4, DEAD_CYCLES=1, AN_ACTIVE_LOW=1 -> an=4'b1111, seg=7'h00, frame_done=0. Digit 0 slot begins after release.
- Basic scan: load value=16'h12AF, dp=4'b0100, wait one frame boundary.
  - Per slot, after 1 dead cycle: an=1110 with seg=71 (F); an=1101 with seg=77 (A); an=1011 with seg=5B and dp_out=1; an=0111 with seg=06.
  - frame_done pulses every 16 cycles.
- Double buffer: load 16'h1111 mid-frame -> displayed digits unchanged until the next frame_done, then all show 06.
  - Load 16'h2222 exactly on the boundary cycle -> 1111 appears that frame and 2222 the following frame.
- Leading-zero blanking: value=16'h0030 -> digits 3 and 2 blank (seg=00), digit 1 = 4F, digit 0 = 3F.
  - value=16'h0000 -> only digit 0 lit (3F).
  - With BLANK_LEADING=0, all four show 3F.
- Enable/polarity: deassert enable for 5 cycles mid-slot -> an=1111 next cycle; scanning resumes at the correct idx.
  - With SEG_ACTIVE_LOW=1, digit value 8 -> seg=7'h00, and a blanked digit -> seg=7'h7F.
- Reset mid-frame: pending load, then rst in slot 2 -> idx=0, active=0. The discarded pending value never appears, and digit 0 shows 3F after release.
